// File: rtl/axis_ram_writer_radar.sv
// Buffers an AXI4-Stream in an on-chip FWFT FIFO and writes it to DDR as fixed 16-beat AXI3 INCR bursts.
// Optional macro RAM_WRITER_DROP_EN: never backpressure the stream, discard words when full, count them on sts_drop.
module axis_ram_writer_radar #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned AXI_ID_WIDTH     = 6,
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXIS_TDATA_WIDTH = 64,
  parameter int unsigned FIFO_WRITE_DEPTH = 512
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     min_addr,
  input  logic [ADDR_WIDTH-1:0]         cfg_data,
  output logic [ADDR_WIDTH-1:0]         sts_data,
`ifdef RAM_WRITER_DROP_EN
  output logic [15:0]                   sts_drop,
`endif
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [3:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [3:0]                    m_axi_awcache,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready
);

  localparam int unsigned ADDR_SIZE = $clog2(AXI_DATA_WIDTH/8);
  localparam int unsigned PTR_W     = $clog2(FIFO_WRITE_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_WRITE_DEPTH);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(16);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // FIFO: block-RAM array plus a prefetch output register giving first-word-fall-through.
  logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]            count_reg;
  logic [CNT_W-1:0]            mem_count;
  logic [AXIS_TDATA_WIDTH-1:0] dout_reg;
  logic                        dout_valid_reg;
  logic                        fifo_full, fifo_wr, fifo_rd, fifo_load;

  state_t                      state_reg, state_next;
  logic [3:0]                  beat_reg;
  logic [ADDR_WIDTH-1:0]       int_addr_reg, int_data_reg;
  logic                        unused_inputs;

  assign fifo_full = (count_reg == DEPTH_C);
  // count_reg includes the word held in the output register
  assign mem_count = count_reg - CNT_W'(dout_valid_reg);
  assign fifo_load = (mem_count != '0) && (!dout_valid_reg || fifo_rd);
  assign fifo_rd   = m_axi_wvalid && m_axi_wready;

`ifdef RAM_WRITER_DROP_EN
  logic [15:0] drop_cnt_reg;

  assign s_axis_tready = 1'b1;
  assign fifo_wr       = s_axis_tvalid && !fifo_full;
  assign sts_drop      = drop_cnt_reg;

  always_ff @(posedge aclk) begin
    if (!aresetn)
      drop_cnt_reg <= '0;
    else if (s_axis_tvalid && fifo_full && (drop_cnt_reg != 16'hFFFF))
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end
`else
  assign s_axis_tready = !fifo_full;
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;
`endif

  always_ff @(posedge aclk) begin
    if (fifo_wr)
      mem[wr_ptr_reg] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (fifo_load)
      dout_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (fifo_wr)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (fifo_load)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (fifo_load)
        dout_valid_reg <= 1'b1;
      else if (fifo_rd)
        dout_valid_reg <= 1'b0;
      count_reg <= count_reg + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg >= BURST_C) state_next = ADDR;
      ADDR:    if (m_axi_awready) state_next = DATA;
      DATA:    if (fifo_rd && m_axi_wlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = (state_reg == ADDR);
    m_axi_wvalid  = (state_reg == DATA) && dout_valid_reg;
    m_axi_wlast   = (state_reg == DATA) && (beat_reg == 4'd15);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)
      beat_reg <= '0;
    else if (fifo_rd)
      beat_reg <= m_axi_wlast ? 4'd0 : beat_reg + 4'd1;
  end

  // Same slot walk as the DDR reader: step until the limit, then reload quarter base and limit.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      int_addr_reg <= '0;
      int_data_reg <= '0;
    end else if (m_axi_awvalid && m_axi_awready) begin
      if (int_addr_reg < int_data_reg) begin
        int_addr_reg <= int_addr_reg + ADDR_WIDTH'(1);
      end else begin
        int_addr_reg <= {cfg_data[ADDR_WIDTH-1:ADDR_WIDTH-2], {(ADDR_WIDTH-2){1'b0}}};
        int_data_reg <= cfg_data;
      end
    end
  end

  assign m_axi_awaddr  = min_addr + AXI_ADDR_WIDTH'({int_addr_reg, 4'd0, {ADDR_SIZE{1'b0}}});
  assign sts_data      = int_addr_reg;
  assign m_axi_awid    = '0;
  assign m_axi_awlen   = 4'd15;
  assign m_axi_awsize  = 3'(ADDR_SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0110;
  assign m_axi_wid     = '0;
  assign m_axi_wdata   = AXI_DATA_WIDTH'(dout_reg);
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;
  assign unused_inputs = &{1'b0, m_axi_bvalid};

endmodule

// File: tb/tb_axis_ram_writer_radar.sv
// Directed bench for axis_ram_writer_radar: burst addressing, wrap, backpressure, threshold and overflow.
// Build with RAM_WRITER_DROP_EN defined to exercise the drop variant.
module tb_axis_ram_writer_radar;

  logic        aclk;
  logic        aresetn;
  logic [31:0] min_addr;
  logic [15:0] cfg_data;
  logic [15:0] sts_data;
`ifdef RAM_WRITER_DROP_EN
  logic [15:0] sts_drop;
`endif
  logic [5:0]  m_axi_awid;
  logic [3:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [3:0]  m_axi_awcache;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [5:0]  m_axi_wid;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  int checks = 0;
  int failures = 0;
  int wready_mode = 1;  // 0 low, 1 high, 2 toggle every cycle

  logic [31:0] aw_q[$];
  logic [63:0] w_q[$];
  logic        wl_q[$];

  axis_ram_writer_radar dut (
    .aclk(aclk), .aresetn(aresetn), .min_addr(min_addr), .cfg_data(cfg_data), .sts_data(sts_data),
`ifdef RAM_WRITER_DROP_EN
    .sts_drop(sts_drop),
`endif
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wid(m_axi_wid),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    m_axi_wready = 0;
    forever begin
      @(posedge aclk); #1;
      case (wready_mode)
        0: m_axi_wready = 0;
        1: m_axi_wready = 1;
        default: m_axi_wready = ~m_axi_wready;
      endcase
    end
  end

  // Handshake recorder; one line per address transaction
  always @(negedge aclk) begin
    if (aresetn && m_axi_awvalid && m_axi_awready) begin
      aw_q.push_back(m_axi_awaddr);
      $display("AW burst=%0d addr=%h", aw_q.size(), m_axi_awaddr);
    end
    if (aresetn && m_axi_wvalid && m_axi_wready) begin
      w_q.push_back(m_axi_wdata);
      wl_q.push_back(m_axi_wlast);
    end
  end

  task automatic do_reset();
    aresetn = 0;
    s_axis_tvalid = 0;
    repeat (3) @(posedge aclk);
    #1;
    aw_q.delete(); w_q.delete(); wl_q.delete();
    aresetn = 1;
    @(posedge aclk); #1;
  endtask

  task automatic send_words(input int first, input int n, input int max_cycles, output int sent);
    int guard = 0;
    sent = 0;
    while (sent < n && guard < max_cycles) begin
      s_axis_tdata = 64'(first + sent);
      s_axis_tvalid = 1;
      @(negedge aclk);
      if (s_axis_tready) sent++;
      @(posedge aclk); #1;
      guard++;
    end
    s_axis_tvalid = 0;
  endtask

  task automatic wait_beats(input int n, input int max_cycles, output bit ok);
    int guard = 0;
    while (w_q.size() < n && guard < max_cycles) begin
      @(posedge aclk); #1;
      guard++;
    end
    ok = (w_q.size() >= n);
  endtask

  task automatic test_reset();
    aresetn = 0;
    @(posedge aclk); #1;
    checks++;
    if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_wlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_in: awvalid=%b wvalid=%b wlast=%b required 0 0 0", m_axi_awvalid, m_axi_wvalid, m_axi_wlast);
    end
    do_reset();
    checks++;
    if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || sts_data !== 16'h0 || s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_out: awvalid=%b wvalid=%b sts=%h tready=%b required 0 0 0000 1",
               m_axi_awvalid, m_axi_wvalid, sts_data, s_axis_tready);
    end
    checks++;
    if (m_axi_awlen !== 4'd15 || m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01 || m_axi_awcache !== 4'b0110 ||
        m_axi_wstrb !== 8'hFF || m_axi_bready !== 1'b1 || m_axi_awid !== 6'd0 || m_axi_wid !== 6'd0) begin
      failures++;
      $display("FAIL consts: len=%h size=%h burst=%h cache=%h strb=%h bready=%b required f 3 1 6 ff 1",
               m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb, m_axi_bready);
    end
`ifdef RAM_WRITER_DROP_EN
    checks++;
    if (sts_drop !== 16'd0) begin
      failures++;
      $display("FAIL reset_drop: sts_drop=%0d required 0", sts_drop);
    end
`endif
  endtask

  task automatic test_bursts();
    logic [31:0] exp_aw [12] = '{32'h10000000, 32'h10000000, 32'h10000080, 32'h10000100, 32'h10000180, 32'h10000000,
                                 32'h10000080, 32'h10000100, 32'h10000180, 32'h10200000, 32'h10200080, 32'h10200100};
    int sent;
    bit ok;
    do_reset();
    min_addr = 32'h1000_0000; cfg_data = 16'h0003; m_axi_awready = 1; wready_mode = 1;
    send_words(0, 96, 300, sent);
    wait_beats(96, 300, ok);
    checks++;
    if (!ok || sts_data !== 16'h0001) begin
      failures++;
      $display("FAIL sweep1: beats=%0d sts=%h required 96 0001", w_q.size(), sts_data);
    end
    cfg_data = 16'h4002;
    send_words(96, 96, 300, sent);
    wait_beats(192, 300, ok);
    repeat (5) @(posedge aclk); #1;
    checks++;
    if (!ok || aw_q.size() != 12 || w_q.size() != 192 || sts_data !== 16'h4000) begin
      failures++;
      $display("FAIL sweep2: aw=%0d beats=%0d sts=%h required 12 192 4000", aw_q.size(), w_q.size(), sts_data);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= aw_q.size() || aw_q[i] !== exp_aw[i]) begin
        failures++;
        $display("FAIL awaddr[%0d]: got %h required %h", i, (i < aw_q.size()) ? aw_q[i] : 32'hx, exp_aw[i]);
      end
    end
    for (int i = 0; i < 192 && i < w_q.size(); i++) begin
      checks++;
      if (w_q[i] !== 64'(i) || wl_q[i] !== (i % 16 == 15)) begin
        failures++;
        $display("FAIL beat[%0d]: data=%0d wlast=%b required %0d %b", i, w_q[i], wl_q[i], i, (i % 16 == 15));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held_data = '0;
    bit held = 0;
    int sent;
    int guard = 0;
    do_reset();
    min_addr = 32'h2000_0000; cfg_data = 16'h0000; m_axi_awready = 0; wready_mode = 2;
    send_words(200, 32, 100, sent);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checks++;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h2000_0000) begin
        failures++;
        $display("FAIL aw_hold[%0d]: awvalid=%b addr=%h required 1 20000000", i, m_axi_awvalid, m_axi_awaddr);
      end
    end
    @(posedge aclk); #1;
    m_axi_awready = 1;
    while (w_q.size() < 32 && guard < 400) begin
      @(negedge aclk);
      if (held) begin
        checks++;
        if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== held_data) begin
          failures++;
          $display("FAIL w_hold: wvalid=%b data=%0d required 1 %0d", m_axi_wvalid, m_axi_wdata, held_data);
        end
      end
      held = m_axi_wvalid && !m_axi_wready;
      held_data = m_axi_wdata;
      guard++;
    end
    @(posedge aclk); #1;
    wready_mode = 1;
    repeat (3) @(posedge aclk); #1;
    checks++;
    if (aw_q.size() != 2 || w_q.size() != 32 || aw_q[0] !== 32'h2000_0000 || aw_q[1] !== 32'h2000_0000) begin
      failures++;
      $display("FAIL bp_counts: aw=%0d beats=%0d required 2 32 at 20000000", aw_q.size(), w_q.size());
    end
    for (int i = 0; i < 32 && i < w_q.size(); i++) begin
      checks++;
      if (w_q[i] !== 64'(200 + i) || wl_q[i] !== (i % 16 == 15)) begin
        failures++;
        $display("FAIL bp_beat[%0d]: data=%0d wlast=%b required %0d %b", i, w_q[i], wl_q[i], 200 + i, (i % 16 == 15));
      end
    end
  endtask

  task automatic test_threshold();
    int sent;
    bit seen_aw = 0;
    bit ok;
    do_reset();
    min_addr = 32'h0; cfg_data = 16'h0; m_axi_awready = 1; wready_mode = 1;
    send_words(300, 15, 50, sent);
    for (int i = 0; i < 30; i++) begin
      @(negedge aclk);
      if (m_axi_awvalid) seen_aw = 1;
    end
    @(posedge aclk); #1;
    checks++;
    if (seen_aw || aw_q.size() != 0) begin
      failures++;
      $display("FAIL below_16: awvalid_seen=%b aw=%0d required 0 0", seen_aw, aw_q.size());
    end
    send_words(315, 1, 10, sent);
    checks++;
    if (m_axi_awvalid !== 1'b0) begin
      failures++;
      $display("FAIL aw_early: awvalid=%b required 0", m_axi_awvalid);
    end
    @(posedge aclk); #1;
    checks++;
    if (m_axi_awvalid !== 1'b1) begin
      failures++;
      $display("FAIL aw_rise: awvalid=%b required 1", m_axi_awvalid);
    end
    wait_beats(16, 100, ok);
    checks++;
    if (!ok || w_q[0] !== 64'd300 || w_q[15] !== 64'd315 || wl_q[15] !== 1'b1) begin
      failures++;
      $display("FAIL th_burst: beats=%0d first=%0d last=%0d required 16 300 315", w_q.size(), w_q[0], w_q[15]);
    end
  endtask

  task automatic test_overflow();
    int sent;
    bit ok;
    do_reset();
    min_addr = 32'h0; cfg_data = 16'h0; m_axi_awready = 0; wready_mode = 1;
    send_words(0, 600, 700, sent);
    @(posedge aclk); #1;
`ifdef RAM_WRITER_DROP_EN
    checks++;
    if (sent != 600 || sts_drop !== 16'd88 || s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL drop: sent=%0d sts_drop=%0d tready=%b required 600 88 1", sent, sts_drop, s_axis_tready);
    end
`else
    checks++;
    if (sent != 512 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL full: accepted=%0d tready=%b required 512 0", sent, s_axis_tready);
    end
`endif
    m_axi_awready = 1;
    wait_beats(512, 1500, ok);
    repeat (5) @(posedge aclk); #1;
    checks++;
    if (!ok || w_q.size() != 512 || aw_q.size() != 32 || w_q[0] !== 64'd0 || w_q[511] !== 64'd511) begin
      failures++;
      $display("FAIL drain: beats=%0d aw=%0d first=%0d last=%0d required 512 32 0 511",
               w_q.size(), aw_q.size(), w_q[0], w_q[511]);
    end
  endtask

  initial begin
    aresetn = 0; min_addr = 0; cfg_data = 0; m_axi_awready = 0; m_axi_bvalid = 0;
    s_axis_tdata = 0; s_axis_tvalid = 0;
    test_reset();
    test_bursts();
    test_backpressure();
    test_threshold();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
